// File: rtl/uart_write_pack_pkg.sv
`default_nettype none
// ============================================================================
// uart_write_pack_pkg : shared DDR word geometry and write-pack FSM encoding
// Rev 1.0
// ============================================================================
package uart_write_pack_pkg;

  localparam int DDR_DATA_W = 256;
  localparam int DDR_NBYTES = DDR_DATA_W / 8;

  // Byte 0 of a word (first byte on the wire) lands in bits [7:0].
  localparam bit BYTE0_AT_LSB = 1'b1;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_write_pack_if.sv
`default_nettype none
// ============================================================================
// uart_write_pack_if : UART byte input and AXI write-word output handshakes
// Rev 1.0
// ============================================================================
interface uart_write_pack_if
  import uart_write_pack_pkg::*;
#(
  parameter int DATA_W = DDR_DATA_W
);

  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_wr_valid;
  logic              i_wr_ready;

  modport master (
    output i_byte, i_byte_valid, i_wr_ready,
    input  o_byte_ready, o_wr_data, o_wr_valid
  );

  modport slave (
    input  i_byte, i_byte_valid, i_wr_ready,
    output o_byte_ready, o_wr_data, o_wr_valid
  );

endinterface
`default_nettype wire

// File: rtl/uart_wr_slot.sv
`default_nettype none
// ============================================================================
// uart_wr_slot : single-entry valid/ready holding register for finished words
// Rev 1.0
// ============================================================================
module uart_wr_slot
  import uart_write_pack_pkg::*;
#(
  parameter int DATA_W = DDR_DATA_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_wr_ready,
  output logic              o_wr_valid,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_free
);

  // Free when empty or when the held word leaves at this edge.
  assign o_free = !o_wr_valid || i_wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr_valid <= 1'b0;
      o_wr_data  <= '0;
    end else if (i_load) begin
      o_wr_valid <= 1'b1;
      o_wr_data  <= i_load_data;
    end else if (i_wr_ready) begin
      o_wr_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_write_pack.sv
`default_nettype none
// ============================================================================
// uart_write_pack : packs UART bytes into DDR words, double-buffered output
// Rev 1.0
// ============================================================================
module uart_write_pack
  import uart_write_pack_pkg::*;
#(
  parameter  int DATA_W = DDR_DATA_W,
  parameter  int CNT_W  = 16,
  localparam int NBYTES = DATA_W / 8,
  localparam int IDX_W  = $clog2(NBYTES)
)(
  input  logic              Axi0Clk,
  input  logic              rst,
  input  logic              i_clr,
  uart_write_pack_if.slave  bus,
  output logic [IDX_W-1:0]  o_byte_cnt,
  output logic [CNT_W-1:0]  o_word_cnt,
  output logic              o_overflow
);

  fill_state_t       r_state;
  logic              r_byte_ready;
  logic [DATA_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_word_cnt;

  logic [DATA_W-1:0] w_acc_next;
  logic [IDX_W-1:0]  w_lane;
  logic              w_accept;
  logic              w_last;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic              w_slot_free;
  logic              w_wr_valid;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_handshake;

  assign w_accept    = bus.i_byte_valid && r_byte_ready && !i_clr;
  assign w_last      = w_accept && (r_idx == IDX_W'(NBYTES - 1));
  assign w_lane      = BYTE0_AT_LSB ? r_idx : (IDX_W'(NBYTES - 1) - r_idx);
  assign w_handshake = w_wr_valid && bus.i_wr_ready;

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(w_lane) * 8 +: 8] = bus.i_byte;
  end

  // A clear in FULL discards the parked word, so it must not reach the slot.
  assign w_load      = (r_state == ST_FILL) ? (w_last && w_slot_free)
                                            : (w_slot_free && !i_clr);
  assign w_load_data = (r_state == ST_FILL) ? w_acc_next : r_acc;

  uart_wr_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk         (Axi0Clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_wr_ready  (bus.i_wr_ready),
    .o_wr_valid  (w_wr_valid),
    .o_wr_data   (w_wr_data),
    .o_free      (w_slot_free)
  );

  always_ff @(posedge Axi0Clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_byte_ready <= 1'b1;
      r_acc        <= '0;
      r_idx        <= '0;
    end else if (i_clr) begin
      r_state      <= ST_FILL;
      r_byte_ready <= 1'b1;
      r_acc        <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_last && !w_slot_free) begin
              r_state      <= ST_FULL;
              r_byte_ready <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (w_slot_free) begin
            r_state      <= ST_FILL;
            r_byte_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_FILL;
          r_byte_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Axi0Clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_overflow <= 1'b0;
    end else if (bus.i_byte_valid && !r_byte_ready) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge Axi0Clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_handshake) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign bus.o_byte_ready = r_byte_ready;
  assign bus.o_wr_valid   = w_wr_valid;
  assign bus.o_wr_data    = w_wr_data;
  assign o_byte_cnt       = (r_state == ST_FILL) ? r_idx : '0;
  assign o_word_cnt       = r_word_cnt;
  assign o_overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_write_pack.sv
`default_nettype none
// ============================================================================
// tb_uart_write_pack : scoreboard bench for the UART-to-DDR word packer
// Rev 1.0
// ============================================================================
module tb_uart_write_pack;
  import uart_write_pack_pkg::*;

  localparam int DW = 256;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic clr1;

  always #5 clk = ~clk;

  uart_write_pack_if #(.DATA_W(DW)) bus ();
  uart_write_pack_if #(.DATA_W(DW)) bus1 ();

  logic [4:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic        ovf;
  logic [4:0]  byte_cnt1;
  logic [1:0]  word_cnt1;
  logic        ovf1;

  uart_write_pack #(.DATA_W(DW), .CNT_W(16)) dut (
    .Axi0Clk    (clk),
    .rst        (rst),
    .i_clr      (clr),
    .bus        (bus),
    .o_byte_cnt (byte_cnt),
    .o_word_cnt (word_cnt),
    .o_overflow (ovf)
  );

  uart_write_pack #(.DATA_W(DW), .CNT_W(2)) dut1 (
    .Axi0Clk    (clk),
    .rst        (rst),
    .i_clr      (clr1),
    .bus        (bus1),
    .o_byte_cnt (byte_cnt1),
    .o_word_cnt (word_cnt1),
    .o_overflow (ovf1)
  );

  int tests_run = 0;
  int fails     = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_acc;
  int            mdl_idx;
  logic [DW-1:0] mon_exp;

  // Scoreboard: every handshake on the main instance must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.o_wr_valid && bus.i_wr_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL word_unexpected: got %h, none expected", bus.o_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.o_wr_data !== mon_exp) begin
          fails++;
          $display("FAIL word_data: got %h, expected %h", bus.o_wr_data, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    mdl_acc = '0;
    mdl_idx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_acc);
    tests_run++;
    if (bus.o_byte_ready !== exp_acc) begin
      fails++;
      $display("FAIL byte_ready: got %b, expected %b (byte %h)", bus.o_byte_ready, exp_acc, b);
    end
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    tick(1);
    bus.i_byte_valid = 1'b0;
    if (exp_acc) begin
      mdl_acc[8*mdl_idx +: 8] = b;
      mdl_idx++;
      if (mdl_idx == NB) begin
        exp_q.push_back(mdl_acc);
        model_reset();
      end
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    tests_run++;
    if (bus.o_wr_valid !== 1'b0 || bus.o_wr_data !== '0 || byte_cnt !== 5'd0 ||
        word_cnt !== 16'd0 || ovf !== 1'b0 || bus.o_byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got valid=%b cnt=%0d words=%0d ovf=%b ready=%b, expected 0 0 0 0 1",
               bus.o_wr_valid, byte_cnt, word_cnt, ovf, bus.o_byte_ready);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_word();
    int early = 0;
    bus.i_wr_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      send_byte(8'(i), 1'b1);
      if (i < NB - 1 && bus.o_wr_valid) early++;
    end
    tests_run++;
    if (early != 0 || bus.o_wr_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: got early=%0d valid=%b, expected 0 1", early, bus.o_wr_valid);
    end
    tick(1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b0 || word_cnt !== 16'd1) begin
      fails++;
      $display("FAIL basic_after: got valid=%b words=%0d, expected 0 1", bus.o_wr_valid, word_cnt);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.i_wr_ready = 1'b0;
    for (int i = 0; i < 2 * NB; i++) send_byte(8'(i), 1'b1);
    tests_run++;
    if (bus.o_byte_ready !== 1'b0 || bus.o_wr_valid !== 1'b1 || byte_cnt !== 5'd0) begin
      fails++;
      $display("FAIL bp_full: got ready=%b valid=%b cnt=%0d, expected 0 1 0",
               bus.o_byte_ready, bus.o_wr_valid, byte_cnt);
    end
    send_byte(8'hAA, 1'b0);
    tests_run++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL bp_overflow: got %b, expected 1", ovf);
    end
    bus.i_wr_ready = 1'b1;
    tick(1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b1 || bus.o_byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_refill: got valid=%b ready=%b, expected 1 1", bus.o_wr_valid, bus.o_byte_ready);
    end
    tick(1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b0 || word_cnt !== 16'd3 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL bp_after: got valid=%b words=%0d ovf=%b, expected 0 3 1", bus.o_wr_valid, word_cnt, ovf);
    end
    wait_drain();
  endtask

  task automatic test_clear();
    bus.i_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 1'b1);
    clr              = 1'b1;
    bus.i_byte       = 8'h55;
    bus.i_byte_valid = 1'b1;
    tick(1);
    clr              = 1'b0;
    bus.i_byte_valid = 1'b0;
    model_reset();
    tests_run++;
    if (byte_cnt !== 5'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL clear_state: got cnt=%0d ovf=%b, expected 0 0", byte_cnt, ovf);
    end
    for (int i = 0; i < NB; i++) send_byte(8'h80 + 8'(i), 1'b1);
    wait_drain();
    tests_run++;
    if (word_cnt !== 16'd4) begin
      fails++;
      $display("FAIL clear_words: got %0d, expected 4", word_cnt);
    end
  endtask

  task automatic test_drain_and_complete();
    bus.i_wr_ready = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(8'(i * 3), 1'b1);
    for (int i = 0; i < NB - 1; i++) send_byte(8'(255 - i), 1'b1);
    bus.i_wr_ready = 1'b1;
    send_byte(8'(255 - (NB - 1)), 1'b1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b1 || bus.o_byte_ready !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL sim_reload: got valid=%b ready=%b ovf=%b, expected 1 1 0",
               bus.o_wr_valid, bus.o_byte_ready, ovf);
    end
    tick(1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b0 || word_cnt !== 16'd6) begin
      fails++;
      $display("FAIL sim_after: got valid=%b words=%0d, expected 0 6", bus.o_wr_valid, word_cnt);
    end
    wait_drain();
  endtask

  task automatic test_async_reset();
    bus.i_wr_ready = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(8'h11 + 8'(i), 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'h90 + 8'(i), 1'b1);
    tests_run++;
    if (bus.o_wr_valid !== 1'b1 || byte_cnt !== 5'd7) begin
      fails++;
      $display("FAIL arst_pre: got valid=%b cnt=%0d, expected 1 7", bus.o_wr_valid, byte_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.o_wr_valid !== 1'b0 || byte_cnt !== 5'd0 || word_cnt !== 16'd0 || bus.o_wr_data !== '0) begin
      fails++;
      $display("FAIL arst_immediate: got valid=%b cnt=%0d words=%0d, expected 0 0 0",
               bus.o_wr_valid, byte_cnt, word_cnt);
    end
    exp_q.delete();
    model_reset();
    tick(1);
    rst = 1'b0;
    bus.i_wr_ready = 1'b1;
    for (int i = 0; i < NB; i++) send_byte(8'hF0 - 8'(i), 1'b1);
    wait_drain();
    tests_run++;
    if (word_cnt !== 16'd1) begin
      fails++;
      $display("FAIL arst_after: got words=%0d, expected 1", word_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    logic [DW-1:0] w_exp;
    logic [1:0]    c_exp;
    bus1.i_wr_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      w_exp = '0;
      for (int i = 0; i < NB; i++) begin
        bus1.i_byte       = 8'(w * 37 + i);
        bus1.i_byte_valid = 1'b1;
        w_exp[8*i +: 8]   = 8'(w * 37 + i);
        tick(1);
      end
      bus1.i_byte_valid = 1'b0;
      tests_run++;
      if (bus1.o_wr_valid !== 1'b1 || bus1.o_wr_data !== w_exp) begin
        fails++;
        $display("FAIL wrap_word%0d: got valid=%b data=%h, expected 1 %h", w, bus1.o_wr_valid, bus1.o_wr_data, w_exp);
      end
      tick(1);
      c_exp = 2'(w + 1);
      tests_run++;
      if (word_cnt1 !== c_exp) begin
        fails++;
        $display("FAIL wrap_count%0d: got %0d, expected %0d", w, word_cnt1, c_exp);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    clr               = 1'b0;
    clr1              = 1'b0;
    bus.i_byte        = 8'h00;
    bus.i_byte_valid  = 1'b0;
    bus.i_wr_ready    = 1'b0;
    bus1.i_byte       = 8'h00;
    bus1.i_byte_valid = 1'b0;
    bus1.i_wr_ready   = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_basic_word();
    test_backpressure();
    test_clear();
    test_drain_and_complete();
    test_async_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
